// File: rtl/test_sequencer_pkg.sv
// Shared definitions for the test sequencer: FSM state encoding and a
// constant-width helper used to size the stage index.
package test_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  // Ceiling log2, used for elaboration-time widths only.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/test_sequencer_seq_watchdog.sv
// Per-stage watchdog for the test sequencer.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clr        - synchronous clear to zero (priority over en)
//   en         - count one per cycle; saturates at all-ones
//   expired    - high while count == TIMEOUT-1
module seq_watchdog #(
  parameter int          TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/test_sequencer.sv
// Start/finish sequencer for a chain of self-checking units. Launches one
// unit at a time, waits for its finish under a per-stage watchdog, records
// pass / timeout per stage and raises one overall finish.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for go
// LAUNCH  | clear watchdog, start of active stage registered this cycle
// WAIT    | stage_start high, waiting for finish or timeout
// ADVANCE | stage_start low (inter-stage gap), pick next stage or end
// DONE    | run complete, finish held until the next go
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   go           - run request, accepted in IDLE/DONE only
//   stage_finish - per-unit finish level
//   stage_pass   - per-unit verdict, valid with its finish
//   stage_start  - one-hot start level to the active unit
//   cur_stage    - index of the active or last stage
//   busy         - run in progress
//   finish       - run complete
//   pass_mask    - per-stage pass results
//   tmo_mask     - per-stage timeout results
//   all_pass     - finish with every stage passed
//   seq_err      - sticky: a non-active unit raised finish during a run
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int          N_STAGES     = 8,
  parameter int          TIMEOUT_W    = 16,
  parameter int unsigned TIMEOUT      = 16'hFFFF,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  input  logic [N_STAGES-1:0]          stage_finish,
  input  logic [N_STAGES-1:0]          stage_pass,
  output logic [N_STAGES-1:0]          stage_start,
  output logic [clog2(N_STAGES)-1:0]   cur_stage,
  output logic                         busy,
  output logic                         finish,
  output logic [N_STAGES-1:0]          pass_mask,
  output logic [N_STAGES-1:0]          tmo_mask,
  output logic                         all_pass,
  output logic                         seq_err
);

  localparam int IDX_W = clog2(N_STAGES);
  localparam logic [N_STAGES-1:0] ONE = {{(N_STAGES-1){1'b0}}, 1'b1};

  seq_state_t          state, state_nxt;
  logic [IDX_W-1:0]    cur_nxt;
  logic [N_STAGES-1:0] start_nxt, pass_nxt, tmo_nxt;
  logic                err_nxt;
  logic                launch_q;
  logic                wd_clr, wd_en, wd_expired;
  logic [N_STAGES-1:0] cur_onehot, prev_onehot, tolerated, stray;
  logic                cur_fin, cur_pass, last_stage;

  seq_watchdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign cur_onehot  = ONE << cur_stage;
  // Shifting right gives the previous stage, and nothing for stage 0.
  assign prev_onehot = cur_onehot >> 1;
  // The unit that just ended may still hold finish while the next stage
  // launches and during that stage's first WAIT cycle.
  assign tolerated   = (state == LAUNCH || launch_q) ? prev_onehot : '0;
  assign stray       = stage_finish & ~cur_onehot & ~tolerated;
  assign cur_fin     = |(stage_finish & cur_onehot);
  assign cur_pass    = |(stage_pass & cur_onehot);
  assign last_stage  = (cur_stage == IDX_W'(N_STAGES - 1));

  assign busy     = (state == LAUNCH) || (state == WAIT) || (state == ADVANCE);
  assign finish   = (state == DONE);
  assign all_pass = finish & (&pass_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_stage   <= '0;
      stage_start <= '0;
      pass_mask   <= '0;
      tmo_mask    <= '0;
      seq_err     <= 1'b0;
      launch_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_stage   <= cur_nxt;
      stage_start <= start_nxt;
      pass_mask   <= pass_nxt;
      tmo_mask    <= tmo_nxt;
      seq_err     <= err_nxt;
      launch_q    <= (state == LAUNCH);
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_stage;
    start_nxt = stage_start;
    pass_nxt  = pass_mask;
    tmo_nxt   = tmo_mask;
    err_nxt   = seq_err;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    if (busy && (|stray)) begin
      err_nxt = 1'b1;
    end

    case (state)
      IDLE, DONE: begin
        if (go) begin
          pass_nxt  = '0;
          tmo_nxt   = '0;
          err_nxt   = 1'b0;
          cur_nxt   = '0;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_clr    = 1'b1;
        start_nxt = cur_onehot;
        state_nxt = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // Finish takes priority over a timeout in the same cycle.
        if (cur_fin) begin
          pass_nxt[cur_stage] = cur_pass;
          start_nxt           = '0;
          state_nxt           = ADVANCE;
        end else if (wd_expired) begin
          tmo_nxt[cur_stage] = 1'b1;
          start_nxt          = '0;
          state_nxt          = ADVANCE;
        end
      end
      ADVANCE: begin
        if (last_stage || (STOP_ON_FAIL && !pass_mask[cur_stage])) begin
          state_nxt = DONE;
        end else begin
          cur_nxt   = cur_stage + IDX_W'(1);
          state_nxt = LAUNCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: two instances (run-to-end and stop-on-fail),
// behavioural unit responders, and a start-order scoreboard.
module tb_test_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic go [2];
  logic [N-1:0] sfin [2];
  logic [N-1:0] spass [2];
  logic [N-1:0] sstart [2];
  logic [1:0]   cur [2];
  logic busy [2];
  logic fin [2];
  logic allp [2];
  logic serr [2];
  logic [N-1:0] pmask [2];
  logic [N-1:0] tmask [2];

  int checks = 0;
  int errors = 0;

  int dly [2][N];
  bit pv [2][N];
  bit inj [2][N];
  int hold [2][N];
  int cnt [2][N];
  int hcnt [2][N];

  int exp_q [2][$];
  logic [N-1:0] prev_start [2];
  logic [N-1:0] seen [2];

  always #5 clk = ~clk;

  test_sequencer #(.N_STAGES(N), .TIMEOUT_W(8), .TIMEOUT(16), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .go(go[0]), .stage_finish(sfin[0]), .stage_pass(spass[0]),
    .stage_start(sstart[0]), .cur_stage(cur[0]), .busy(busy[0]), .finish(fin[0]),
    .pass_mask(pmask[0]), .tmo_mask(tmask[0]), .all_pass(allp[0]), .seq_err(serr[0])
  );

  test_sequencer #(.N_STAGES(N), .TIMEOUT_W(8), .TIMEOUT(16), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go[1]), .stage_finish(sfin[1]), .stage_pass(spass[1]),
    .stage_start(sstart[1]), .cur_stage(cur[1]), .busy(busy[1]), .finish(fin[1]),
    .pass_mask(pmask[1]), .tmo_mask(tmask[1]), .all_pass(allp[1]), .seq_err(serr[1])
  );

  // Unit responders: finish (with verdict) dly cycles after start rises,
  // optionally held for hold cycles after start drops; inj forces a stray finish.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) begin
          if (sstart[k][i]) begin
            cnt[k][i] = cnt[k][i] + 1;
            if (dly[k][i] != 0 && cnt[k][i] >= dly[k][i]) begin
              sfin[k][i]  = 1'b1;
              spass[k][i] = pv[k][i];
              hcnt[k][i]  = hold[k][i];
            end
          end else begin
            cnt[k][i] = 0;
            if (hcnt[k][i] > 0) begin
              hcnt[k][i] = hcnt[k][i] - 1;
            end else begin
              sfin[k][i]  = inj[k][i];
              spass[k][i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Scoreboard: every rising stage_start must match the next expected stage.
  initial begin
    int e;
    logic [N-1:0] want;
    logic [N-1:0] one;
    one = 1;
    prev_start[0] = '0;
    prev_start[1] = '0;
    seen[0] = '0;
    seen[1] = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        seen[k] = seen[k] | sstart[k];
        if (sstart[k] != '0 && prev_start[k] == '0) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL start_order inst%0d: got stage_start %b, expected no start", k, sstart[k]);
          end else begin
            e = exp_q[k].pop_front();
            want = one << e;
            if (sstart[k] !== want) begin
              errors++;
              $display("FAIL start_order inst%0d: got stage_start %b, expected %b", k, sstart[k], want);
            end
          end
        end
        prev_start[k] = sstart[k];
      end
    end
  end

  task automatic set_units(input int k, input int d, input bit p, input int h);
    for (int i = 0; i < N; i++) begin
      dly[k][i]  = d;
      pv[k][i]   = p;
      hold[k][i] = h;
      inj[k][i]  = 1'b0;
    end
  endtask

  task automatic push_order(input int k, input int n);
    for (int i = 0; i < n; i++) exp_q[k].push_back(i);
  endtask

  task automatic pulse_go(input int k);
    repeat (6) @(negedge clk);
    go[k] = 1'b1;
    @(negedge clk);
    go[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (fin[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_start(input int k, input int s, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sstart[k][s] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sstart[k], cur[k], busy[k], fin[k], pmask[k], tmask[k], allp[k], serr[k]} !== 18'd0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got %h, expected 0", k,
                 {sstart[k], cur[k], busy[k], fin[k], pmask[k], tmask[k], allp[k], serr[k]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy[0], fin[0], sstart[0]} !== 6'd0) begin
      errors++;
      $display("FAIL idle_no_go: got %b, expected 0", {busy[0], fin[0], sstart[0]});
    end
  endtask

  task automatic test_all_pass;
    bit ok;
    set_units(0, 5, 1'b1, 0);
    push_order(0, N);
    pulse_go(0);
    checks++;
    if (busy[0] !== 1'b1 || sstart[0] !== 4'b0000) begin
      errors++;
      $display("FAIL launch_cycle: got busy %b start %b, expected busy 1 start 0000", busy[0], sstart[0]);
    end
    @(negedge clk);
    checks++;
    if (sstart[0] !== 4'b0001) begin
      errors++;
      $display("FAIL start_latency: got %b, expected 0001", sstart[0]);
    end
    wait_done(0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL all_pass_done: got no finish, expected finish");
    end
    checks++;
    if ({pmask[0], tmask[0], allp[0], cur[0], busy[0], serr[0]} !== {4'hF, 4'h0, 1'b1, 2'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL all_pass_result: got pass %b tmo %b all %b cur %0d busy %b err %b, expected 1111 0000 1 3 0 0",
               pmask[0], tmask[0], allp[0], cur[0], busy[0], serr[0]);
    end
    checks++;
    if (exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL all_pass_starts: got %0d stages not started, expected 0", exp_q[0].size());
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    set_units(0, 5, 1'b1, 0);
    dly[0][2] = 0;
    push_order(0, N);
    pulse_go(0);
    wait_start(0, 2, ok);
    n = 0;
    while (ok && sstart[0][2] === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_wait_cycles: got %0d, expected 16", n);
    end
    wait_done(0, ok);
    checks++;
    if (!ok || pmask[0] !== 4'b1011 || tmask[0] !== 4'b0100 || allp[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: got done %b pass %b tmo %b all %b, expected 1 1011 0100 0",
               ok, pmask[0], tmask[0], allp[0]);
    end
  endtask

  task automatic test_stop_on_fail;
    bit ok;
    set_units(1, 5, 1'b1, 0);
    pv[1][1] = 1'b0;
    push_order(1, 2);
    seen[1] = '0;
    pulse_go(1);
    wait_done(1, ok);
    checks++;
    if (!ok || cur[1] !== 2'd1 || pmask[1] !== 4'b0001 || tmask[1] !== 4'b0000 || allp[1] !== 1'b0) begin
      errors++;
      $display("FAIL stop_on_fail_result: got done %b cur %0d pass %b tmo %b all %b, expected 1 1 0001 0000 0",
               ok, cur[1], pmask[1], tmask[1], allp[1]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (seen[1][3:2] !== 2'b00 || exp_q[1].size() != 0) begin
      errors++;
      $display("FAIL stop_on_fail_starts: got seen %b pending %0d, expected 00 0", seen[1][3:2], exp_q[1].size());
    end
  endtask

  task automatic test_finish_at_timeout;
    bit ok;
    set_units(0, 5, 1'b1, 0);
    dly[0][0] = 16;
    push_order(0, N);
    pulse_go(0);
    wait_done(0, ok);
    checks++;
    if (!ok || pmask[0] !== 4'b1111 || tmask[0] !== 4'b0000 || allp[0] !== 1'b1) begin
      errors++;
      $display("FAIL finish_on_timeout_cycle: got done %b pass %b tmo %b all %b, expected 1 1111 0000 1",
               ok, pmask[0], tmask[0], allp[0]);
    end
    dly[0][0] = 17;
    push_order(0, N);
    pulse_go(0);
    wait_done(0, ok);
    checks++;
    if (!ok || pmask[0] !== 4'b1110 || tmask[0] !== 4'b0001) begin
      errors++;
      $display("FAIL finish_after_timeout: got done %b pass %b tmo %b, expected 1 1110 0001",
               ok, pmask[0], tmask[0]);
    end
  endtask

  task automatic test_busy_go_seq_err;
    bit ok;
    set_units(0, 5, 1'b1, 0);
    push_order(0, N);
    pulse_go(0);
    wait_start(0, 1, ok);
    go[0] = 1'b1;
    inj[0][3] = 1'b1;
    repeat (2) @(negedge clk);
    inj[0][3] = 1'b0;
    @(negedge clk);
    go[0] = 1'b0;
    checks++;
    if (!ok || serr[0] !== 1'b1 || busy[0] !== 1'b1 || cur[0] !== 2'd1) begin
      errors++;
      $display("FAIL stray_finish: got reached %b err %b busy %b cur %0d, expected 1 1 1 1",
               ok, serr[0], busy[0], cur[0]);
    end
    wait_done(0, ok);
    checks++;
    if (!ok || serr[0] !== 1'b1 || pmask[0] !== 4'hF || exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL go_while_busy: got done %b err %b pass %b pending %0d, expected 1 1 1111 0",
               ok, serr[0], pmask[0], exp_q[0].size());
    end
    push_order(0, N);
    pulse_go(0);
    checks++;
    if (serr[0] !== 1'b0 || fin[0] !== 1'b0) begin
      errors++;
      $display("FAIL seq_err_clear: got err %b finish %b, expected 0 0", serr[0], fin[0]);
    end
    wait_done(0, ok);
  endtask

  task automatic test_handoff;
    bit ok;
    set_units(0, 5, 1'b1, 3);
    push_order(0, N);
    pulse_go(0);
    wait_done(0, ok);
    checks++;
    if (!ok || serr[0] !== 1'b0 || pmask[0] !== 4'hF) begin
      errors++;
      $display("FAIL handoff_tolerated: got done %b err %b pass %b, expected 1 0 1111", ok, serr[0], pmask[0]);
    end
    set_units(0, 5, 1'b1, 4);
    push_order(0, N);
    pulse_go(0);
    wait_done(0, ok);
    checks++;
    if (!ok || serr[0] !== 1'b1) begin
      errors++;
      $display("FAIL handoff_too_long: got done %b err %b, expected 1 1", ok, serr[0]);
    end
    set_units(0, 5, 1'b1, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    bit ok;
    set_units(0, 5, 1'b1, 0);
    dly[0][2] = 0;
    push_order(0, N);
    pulse_go(0);
    wait_start(0, 2, ok);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {sstart[0], cur[0], busy[0], fin[0], pmask[0], tmask[0], allp[0], serr[0]} !== 18'd0) begin
      errors++;
      $display("FAIL reset_midrun: got reached %b outputs %h, expected 1 0", ok,
               {sstart[0], cur[0], busy[0], fin[0], pmask[0], tmask[0], allp[0], serr[0]});
    end
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_units(0, 5, 1'b1, 0);
    push_order(0, N);
    pulse_go(0);
    wait_done(0, ok);
    checks++;
    if (!ok || pmask[0] !== 4'hF || tmask[0] !== 4'h0 || cur[0] !== 2'd3 || exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL restart_after_reset: got done %b pass %b tmo %b cur %0d pending %0d, expected 1 1111 0000 3 0",
               ok, pmask[0], tmask[0], cur[0], exp_q[0].size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      go[k]    = 1'b0;
      sfin[k]  = '0;
      spass[k] = '0;
      for (int i = 0; i < N; i++) begin
        cnt[k][i]  = 0;
        hcnt[k][i] = 0;
      end
      set_units(k, 5, 1'b1, 0);
    end
    test_reset();
    test_all_pass();
    test_timeout();
    test_stop_on_fail();
    test_finish_at_timeout();
    test_busy_go_seq_err();
    test_handoff();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
